// File: rtl/down_counter.sv
// Loadable down counter with a terminal-count pulse and optional auto-reload.
// All state updates on the falling edge of clk. Reset is synchronous and active-high.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             expire;

  // q<=1 is treated as expiry so a RUN state can never wrap below zero.
  assign expire = (state_q == ST_RUN) && en && (cnt_q <= ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_val;
      cnt_d    = load_val;
      if (load_val != ZERO) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end
    end else if (expire) begin
      tc_d = 1'b1;
      if (auto_reload && (reload_q != ZERO)) begin
        cnt_d = reload_q;
      end else begin
        cnt_d   = ZERO;
        state_d = ST_DONE;
      end
    end else if ((state_q == ST_RUN) && en) begin
      cnt_d = cnt_q - ONE;
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: WIDTH=4 main instance plus WIDTH=2 and WIDTH=8 sweeps.
module tb_down_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic       load, en, auto_reload;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy, tc;

  logic       load2, en2;
  logic [1:0] load_val2, q2;
  logic       busy2, tc2;

  logic       load8, en8;
  logic [7:0] load_val8, q8;
  logic       busy8, tc8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .q(q), .busy(busy), .tc(tc));

  down_counter #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .load_val(load_val2), .en(en2),
    .auto_reload(1'b0), .q(q2), .busy(busy2), .tc(tc2));

  down_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load(load8), .load_val(load_val8), .en(en8),
    .auto_reload(1'b0), .q(q8), .busy(busy8), .tc(tc8));

  // Inputs are changed after this returns, well clear of the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = '0;
    load2 = 1'b0; en2 = 1'b0; load_val2 = '0;
    load8 = 1'b0; en8 = 1'b0; load_val8 = '0;
    tick(); tick();
    total++;
    if ({q, busy, tc} !== 6'b0)
      $display("FAIL reset_state: q=%0d busy=%b tc=%b, want 0 0 0", q, busy, tc);
    else passed++;
    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({q, busy, tc} !== 6'b0)
        $display("FAIL idle_en[%0d]: q=%0d busy=%b tc=%b, want 0 0 0", i, q, busy, tc);
      else passed++;
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (q !== 4'd5 || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL oneshot_load: q=%0d busy=%b tc=%b, want 5 1 0", q, busy, tc);
    else passed++;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (q !== exp_q[i] || tc !== (i == 4) || busy !== (i != 4))
        $display("FAIL oneshot_step[%0d]: q=%0d busy=%b tc=%b, want %0d %b %b",
                 i, q, busy, tc, exp_q[i], i != 4, i == 4);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({q, busy, tc} !== 6'b0)
        $display("FAIL oneshot_hold[%0d]: q=%0d busy=%b tc=%b, want 0 0 0", i, q, busy, tc);
      else passed++;
    end
    en = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_q [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    int pulses = 0;
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (q !== 4'd3 || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL reload_load: q=%0d busy=%b tc=%b, want 3 1 0", q, busy, tc);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (tc === 1'b1) pulses++;
      total++;
      if (q !== exp_q[i] || busy !== 1'b1 || tc !== (i % 3 == 2))
        $display("FAIL reload_step[%0d]: q=%0d busy=%b tc=%b, want %0d 1 %b",
                 i, q, busy, tc, exp_q[i], i % 3 == 2);
      else passed++;
    end
    total++;
    if (pulses != 3) $display("FAIL reload_pulses: got %0d, want 3", pulses);
    else passed++;
    // Dropping auto_reload mid-period only matters at the next expiry.
    auto_reload = 1'b0;
    tick(); tick();
    total++;
    if (q !== 4'd1 || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL reload_off_mid: q=%0d busy=%b tc=%b, want 1 1 0", q, busy, tc);
    else passed++;
    tick();
    total++;
    if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b1)
      $display("FAIL reload_off_exp: q=%0d busy=%b tc=%b, want 0 0 1", q, busy, tc);
    else passed++;
    en = 1'b0;
  endtask

  task automatic test_pause_load_priority();
    logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_q  [4] = '{4'd3, 4'd3, 4'd3, 4'd2};
    load = 1'b1; load_val = 4'd4; en = 1'b0; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      tick();
      total++;
      if (q !== exp_q[i] || busy !== 1'b1 || tc !== 1'b0)
        $display("FAIL pause_step[%0d]: q=%0d busy=%b tc=%b, want %0d 1 0", i, q, busy, tc, exp_q[i]);
      else passed++;
    end
    load = 1'b1; load_val = 4'd9; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    total++;
    if (q !== 4'd9 || busy !== 1'b1 || tc !== 1'b0)
      $display("FAIL load_over_en: q=%0d busy=%b tc=%b, want 9 1 0", q, busy, tc);
    else passed++;
  endtask

  task automatic test_zero_and_reset();
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b1)
      $display("FAIL zero_load: q=%0d busy=%b tc=%b, want 0 0 1", q, busy, tc);
    else passed++;
    tick();
    total++;
    if (tc !== 1'b0) $display("FAIL zero_tc_width: tc=%b, want 0", tc);
    else passed++;
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    total++;
    if (q !== 4'd12 || busy !== 1'b1)
      $display("FAIL pre_reset: q=%0d busy=%b, want 12 1", q, busy);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if ({q, busy, tc} !== 6'b0)
      $display("FAIL mid_reset: q=%0d busy=%b tc=%b, want 0 0 0", q, busy, tc);
    else passed++;
    // Reset must also win over a zero load that would otherwise pulse tc.
    load = 1'b1; load_val = 4'd0;
    tick();
    total++;
    if ({q, busy, tc} !== 6'b0)
      $display("FAIL reset_over_load: q=%0d busy=%b tc=%b, want 0 0 0", q, busy, tc);
    else passed++;
    reset = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_width_sweep();
    logic [1:0] exp_q2 [3] = '{2'd2, 2'd1, 2'd0};
    int tcs = 0;
    int edges = 0;
    bit seen = 1'b0;
    load2 = 1'b1; load_val2 = 2'd3;
    load8 = 1'b1; load_val8 = 8'd255;
    tick();
    load2 = 1'b0; load8 = 1'b0;
    total++;
    if (q2 !== 2'd3 || busy2 !== 1'b1 || q8 !== 8'd255 || busy8 !== 1'b1)
      $display("FAIL sweep_load: q2=%0d busy2=%b q8=%0d busy8=%b, want 3 1 255 1", q2, busy2, q8, busy8);
    else passed++;
    en2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tc2 === 1'b1) tcs++;
      if (i < 3) begin
        total++;
        if (q2 !== exp_q2[i])
          $display("FAIL w2_step[%0d]: q=%0d, want %0d", i, q2, exp_q2[i]);
        else passed++;
      end
    end
    total++;
    if (tcs != 1 || q2 !== 2'd0)
      $display("FAIL w2_single_tc: tc count=%0d q=%0d, want 1 0", tcs, q2);
    else passed++;
    en2 = 1'b0;
    en8 = 1'b1;
    while (!seen && edges < 300) begin
      tick();
      edges++;
      if (tc8 === 1'b1) seen = 1'b1;
    end
    en8 = 1'b0;
    total++;
    if (!seen || edges != 255 || q8 !== 8'd0)
      $display("FAIL w8_latency: tc seen=%b after %0d edges q=%0d, want 1 255 0", seen, edges, q8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause_load_priority();
    test_zero_and_reset();
    test_width_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
